// File: rtl/min_countdown_t.sv
// MM:SS BCD down-counter for the snooze/kitchen timer: loads from the set-digit path,
// decrements on the shared 1 Hz tick and pulses expired on reaching 00:00.
// Optional macro COUNTDOWN_AUTORELOAD_EN: reload the last loaded value on expiry and keep running.
module min_countdown_t #(
    parameter int MAX_MIN_TENS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] new_mm_t,
    input  logic [3:0] new_mm_u,
    input  logic [3:0] new_ss_t,
    input  logic [3:0] new_ss_u,
    input  logic       start,
    input  logic       pause,
    input  logic       tick,
    output logic [3:0] mm_t,
    output logic [3:0] mm_u,
    output logic [3:0] ss_t,
    output logic [3:0] ss_u,
    output logic       running,
    output logic       expired,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MIN_TENS);

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        logic [3:0] r;
        if (d > lim) begin
            r = lim;
        end else begin
            r = d;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        expired_q, expired_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic [15:0] load_val_s;
    logic [15:0] dec_val_s;
    logic [15:0] reload_val_s;
    logic        cnt_zero_s;
    logic        cnt_one_s;

    assign load_val_s = {clamp_digit(new_mm_t, MAX_MT), clamp_digit(new_mm_u, 4'd9),
                         clamp_digit(new_ss_t, 4'd5),   clamp_digit(new_ss_u, 4'd9)};
    assign cnt_zero_s = (cnt_q == 16'h0000);
    assign cnt_one_s  = (cnt_q == 16'h0001);

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [15:0] shadow_q, shadow_d;

    // Shadow tracks the last clamped load value
    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = load_val_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow register
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= 16'h0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign reload_val_s = shadow_q;
`else
    assign reload_val_s = 16'h0000;
`endif

    // Borrow chain: ss_u -> ss_t -> mm_u -> mm_t; 00:00 never reaches here
    always_comb begin
        dec_val_s = cnt_q;
        if (cnt_q[3:0] != 4'd0) begin
            dec_val_s[3:0] = cnt_q[3:0] - 4'd1;
        end else begin
            dec_val_s[3:0] = 4'd9;
            if (cnt_q[7:4] != 4'd0) begin
                dec_val_s[7:4] = cnt_q[7:4] - 4'd1;
            end else begin
                dec_val_s[7:4] = 4'd5;
                if (cnt_q[11:8] != 4'd0) begin
                    dec_val_s[11:8] = cnt_q[11:8] - 4'd1;
                end else begin
                    dec_val_s[11:8]  = 4'd9;
                    dec_val_s[15:12] = cnt_q[15:12] - 4'd1;
                end
            end
        end
    end

    // Next-state and next-count; load > pause > start > tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        if (load) begin
            cnt_d   = load_val_s;
            state_d = ST_IDLE;
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end else begin
                state_d = state_q;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !cnt_zero_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_RUN: begin
                    if (tick && cnt_one_s) begin
                        expired_d = 1'b1;
                        if (reload_val_s != 16'h0000) begin
                            cnt_d   = reload_val_s;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d   = 16'h0000;
                            state_d = ST_EXPIRED;
                        end
                    end else if (tick && !cnt_zero_s) begin
                        cnt_d = dec_val_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_EXPIRED);
    end

    // State, count and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            expired_q <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign mm_t    = cnt_q[15:12];
    assign mm_u    = cnt_q[11:8];
    assign ss_t    = cnt_q[7:4];
    assign ss_u    = cnt_q[3:0];
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule
